fifo_rd_packer: RTL and testbench

- Read-side consumer of the async FIFO, in the rd_clk domain.
- Pops WIDTH-bit words whenever the FIFO is not empty and packs PACK consecutive words into one PACK*WIDTH-bit beat.
- Presents each beat on a valid/ready output; throughput is one FIFO word per rd_clk when the output is not back-pressured.
- Flags any FIFO under_flow as a sticky error and counts accepted beats.

---
 rtl/fifo_rd_packer_if.sv | 34 +++
 rtl/fifo_rd_packer.sv | 111 +++++++++++
 tb/tb_fifo_rd_packer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_packer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module     : fifo_rd_packer_if
// Description: FIFO read-side and packed-beat output bundle for
//              fifo_rd_packer. The master modport is the packer; the slave
//              modport is the FIFO/downstream environment.
// Revision   : 1.0 - initial release
// ---------------------------------------------------------------------------
interface fifo_rd_packer_if #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int CNT_W = 16
);
  logic                    empty;
  logic [WIDTH-1:0]        rdata;
  logic                    under_flow;
  logic                    rd_en;
  logic                    out_valid;
  logic                    out_ready;
  logic [PACK*WIDTH-1:0]   out_data;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    err_underflow;

  modport master (
    input  empty, rdata, under_flow, out_ready,
    output rd_en, out_valid, out_data, beat_cnt, err_underflow
  );

  modport slave (
    output empty, rdata, under_flow, out_ready,
    input  rd_en, out_valid, out_data, beat_cnt, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module     : fifo_rd_packer
// Description: Pops WIDTH-bit words from the async FIFO read port and packs
//              PACK consecutive words into one valid/ready output beat
//              (first-popped word in the low bits). Tracks a sticky
//              underflow error and counts accepted beats.
// Revision   : 1.0 - initial release
// ---------------------------------------------------------------------------
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int CNT_W = 16
) (
  input  logic                rd_clk,
  input  logic                res,
  fifo_rd_packer_if.master    bus
);

  // Slot counter must reach PACK to represent the "pack full, waiting" state.
  localparam int SLOT_W = $clog2(PACK + 1);
  localparam logic [SLOT_W-1:0] FULL     = SLOT_W'(PACK);
  localparam logic [SLOT_W-1:0] LAST     = SLOT_W'(PACK - 1);
  localparam logic [SLOT_W:0]   PACK_EXT = (SLOT_W + 1)'(PACK);

  logic [SLOT_W-1:0]      cnt_q, cnt_d;
  logic                   p_q, p_d;
  logic [PACK*WIDTH-1:0]  pack_q, pack_d;
  logic                   out_valid_q, out_valid_d;
  logic [PACK*WIDTH-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                   err_q, err_d;

  logic                   out_free;
  logic [SLOT_W:0]        fill;
  logic                   rd_en;

  // Output register can take a new beat this edge (empty or being drained).
  assign out_free = !out_valid_q || bus.out_ready;
  // Slots already occupied plus the word still in flight.
  assign fill     = {1'b0, cnt_q} + {{SLOT_W{1'b0}}, p_q};
  // Second term keeps pops back-to-back across a beat boundary.
  assign rd_en    = !bus.empty &&
                    ((fill < PACK_EXT) || (p_q && (cnt_q == LAST) && out_free));

  // Next-state: capture in-flight word, complete packs, run the handshake.
  always_comb begin
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    p_d         = rd_en;
    beat_cnt_d  = beat_cnt_q + CNT_W'(out_valid_q && bus.out_ready);
    err_d       = err_q | bus.under_flow;

    if (cnt_q == FULL) begin
      // A completed pack is parked until the output register frees up.
      if (out_free) begin
        out_data_d  = pack_q;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end
    end else if (p_q) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt_q == SLOT_W'(i)) begin
          pack_d[i*WIDTH +: WIDTH] = bus.rdata;
        end
      end
      if (cnt_q == LAST) begin
        if (out_free) begin
          out_data_d  = {bus.rdata, pack_q[(PACK-1)*WIDTH-1:0]};
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = FULL;
        end
      end else begin
        cnt_d = cnt_q + SLOT_W'(1);
      end
    end
  end

  // State registers; reset discards partial packs, pending beats and in-flight reads.
  always_ff @(posedge rd_clk or posedge res) begin
    if (res) begin
      cnt_q       <= '0;
      p_q         <= 1'b0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      pack_q      <= pack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.rd_en         = rd_en;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.beat_cnt      = beat_cnt_q;
  assign bus.err_underflow = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module     : tb_fifo_rd_packer
// Description: Directed self-checking bench for fifo_rd_packer with a simple
//              FIFO read-port model (one-cycle read latency).
// Revision   : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fifo_rd_packer;

  logic rd_clk = 1'b0;
  logic res    = 1'b1;

  fifo_rd_packer_if #(.WIDTH(8), .PACK(4), .CNT_W(16)) bus  ();
  fifo_rd_packer_if #(.WIDTH(8), .PACK(4), .CNT_W(4))  bus4 ();

  fifo_rd_packer #(.WIDTH(8), .PACK(4), .CNT_W(16)) dut (
    .rd_clk (rd_clk),
    .res    (res),
    .bus    (bus)
  );

  fifo_rd_packer #(.WIDTH(8), .PACK(4), .CNT_W(4)) dut4 (
    .rd_clk (rd_clk),
    .res    (res),
    .bus    (bus4)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: word popped at edge N appears on rdata after that edge.
  logic [7:0] mem [0:127];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] fifo_rdata = 8'h00;

  assign bus.empty  = (wr_ptr == rd_ptr);
  assign bus.rdata  = fifo_rdata;
  assign bus4.empty      = bus.empty;
  assign bus4.rdata      = bus.rdata;
  assign bus4.under_flow = bus.under_flow;
  assign bus4.out_ready  = bus.out_ready;

  always @(posedge rd_clk) begin
    if (bus.rd_en && !bus.empty) begin
      fifo_rdata <= mem[rd_ptr[6:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Monitor: count pops, longest pop run, log accepted beats, flag illegal pops.
  int          rd_cnt  = 0;
  int          run     = 0;
  int          max_run = 0;
  int          nb      = 0;
  int          viol    = 0;
  logic [31:0] beats [0:63];

  always @(negedge rd_clk) begin
    if (!res) begin
      if (bus.rd_en && bus.empty) viol <= viol + 1;
      if (bus.rd_en) begin
        rd_cnt <= rd_cnt + 1;
        run    <= run + 1;
        if (run + 1 > max_run) max_run <= run + 1;
      end else begin
        run <= 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        beats[nb[5:0]] <= bus.out_data;
        nb             <= nb + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr[6:0]] = w;
    wr_ptr++;
  endtask

  int rd0, nb0;

  initial begin
    bus.out_ready  = 1'b1;
    bus.under_flow = 1'b0;

    // Reset state, held while res is high
    tick(3);
    check_eq("rst_rd_en",     bus.rd_en,         0);
    check_eq("rst_out_valid", bus.out_valid,     0);
    check_eq("rst_out_data",  bus.out_data,      0);
    check_eq("rst_beat_cnt",  bus.beat_cnt,      0);
    check_eq("rst_err",       bus.err_underflow, 0);
    res = 1'b0;
    tick(2);

    // Single beat from four words
    rd0 = rd_cnt; nb0 = nb;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(10);
    check_eq("t1_rd_cycles", rd_cnt - rd0, 4);
    check_eq("t1_rd_run",    max_run,      4);
    check_eq("t1_nbeats",    nb - nb0,     1);
    check_eq("t1_beat",      beats[0],     32'h44332211);
    check_eq("t1_valid_off", bus.out_valid, 0);
    check_eq("t1_beat_cnt",  bus.beat_cnt, 1);

    // Eight words streamed with no bubble across the beat boundary
    rd0 = rd_cnt; nb0 = nb;
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(14);
    check_eq("t2_rd_cycles", rd_cnt - rd0, 8);
    check_eq("t2_rd_run",    max_run,      8);
    check_eq("t2_nbeats",    nb - nb0,     2);
    check_eq("t2_beat0",     beats[1],     32'h04030201);
    check_eq("t2_beat1",     beats[2],     32'h08070605);
    check_eq("t2_beat_cnt",  bus.beat_cnt, 3);

    // Back-pressure: first beat held, second pack parked full, pops stop
    bus.out_ready = 1'b0;
    rd0 = rd_cnt; nb0 = nb;
    for (int i = 1; i <= 12; i++) push(8'(8'hA0 + i));
    tick(30);
    check_eq("t3_hold_valid", bus.out_valid, 1);
    check_eq("t3_hold_data",  bus.out_data,  32'hA4A3A2A1);
    check_eq("t3_hold_rd_en", bus.rd_en,     0);
    check_eq("t3_hold_pops",  rd_cnt - rd0,  8);
    check_eq("t3_hold_beats", nb - nb0,      0);
    tick(5);
    check_eq("t3_stable_data", bus.out_data, 32'hA4A3A2A1);
    check_eq("t3_stable_rd_en", bus.rd_en,   0);
    bus.out_ready = 1'b1;
    tick(30);
    check_eq("t3_nbeats",   nb - nb0,     3);
    check_eq("t3_beat0",    beats[3],     32'hA4A3A2A1);
    check_eq("t3_beat1",    beats[4],     32'hA8A7A6A5);
    check_eq("t3_beat2",    beats[5],     32'hACABAAA9);
    check_eq("t3_pops",     rd_cnt - rd0, 12);
    check_eq("t3_beat_cnt", bus.beat_cnt, 6);

    // Partial pack held until the fourth word arrives
    nb0 = nb;
    push(8'h31); push(8'h32); push(8'h33);
    tick(10);
    check_eq("t4_part_valid", bus.out_valid, 0);
    check_eq("t4_part_rd_en", bus.rd_en,     0);
    check_eq("t4_part_beats", nb - nb0,      0);
    push(8'h34);
    tick(8);
    check_eq("t4_nbeats",   nb - nb0,     1);
    check_eq("t4_beat",     beats[6],     32'h34333231);
    check_eq("t4_beat_cnt", bus.beat_cnt, 7);

    // Sticky underflow error
    bus.under_flow = 1'b1;
    tick(1);
    bus.under_flow = 1'b0;
    tick(3);
    check_eq("t5_err_set", bus.err_underflow, 1);

    // Reset in the middle of a pack (two words captured)
    push(8'h51); push(8'h52);
    tick(6);
    check_eq("t5_err_sticky", bus.err_underflow, 1);
    check_eq("t5_mid_valid",  bus.out_valid,     0);
    res = 1'b1;
    #1;
    check_eq("t5_rst_rd_en",    bus.rd_en,         0);
    check_eq("t5_rst_valid",    bus.out_valid,     0);
    check_eq("t5_rst_data",     bus.out_data,      0);
    check_eq("t5_rst_beat_cnt", bus.beat_cnt,      0);
    check_eq("t5_rst_err",      bus.err_underflow, 0);
    check_eq("t5_rst_cnt4",     bus4.beat_cnt,     0);
    tick(2);
    res = 1'b0;
    tick(1);
    nb0 = nb;
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    tick(10);
    check_eq("t5_nbeats",   nb - nb0,     1);
    check_eq("t5_beat",     beats[7],     32'h64636261);
    check_eq("t5_beat_cnt", bus.beat_cnt, 1);

    // Sixteen more beats: 17 since reset, 4-bit counter wraps to 1
    nb0 = nb;
    for (int i = 0; i < 64; i++) push(8'(i));
    tick(90);
    check_eq("t6_nbeats",     nb - nb0,      16);
    check_eq("t6_last_beat",  beats[23],     32'h3F3E3D3C);
    check_eq("t6_beat_cnt",   bus.beat_cnt,  17);
    check_eq("t6_beat_cnt4",  bus4.beat_cnt, 1);
    check_eq("t6_fifo_drained", rd_ptr,      wr_ptr);

    check_eq("pop_while_empty", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
